// File: rtl/vtg_pkg.sv
// Shared video timing definitions: timing record, standard 720p/480p modes and a window-decode helper.
package vtg_pkg;

   typedef struct packed {
      logic [31:0] h_active;
      logic [31:0] h_fp;
      logic [31:0] h_sync;
      logic [31:0] h_bp;
      logic [31:0] v_active;
      logic [31:0] v_fp;
      logic [31:0] v_sync;
      logic [31:0] v_bp;
   } vtg_timing_t;

   localparam vtg_timing_t VTG_720P = '{
      h_active: 32'd1280, h_fp: 32'd110, h_sync: 32'd40, h_bp: 32'd220,
      v_active: 32'd720,  v_fp: 32'd5,   v_sync: 32'd5,  v_bp: 32'd20
   };

   localparam vtg_timing_t VTG_480P = '{
      h_active: 32'd640, h_fp: 32'd16, h_sync: 32'd96, h_bp: 32'd48,
      v_active: 32'd480, v_fp: 32'd10, v_sync: 32'd2,  v_bp: 32'd33
   };

   // True when val lies in [lo, lo+len).
   function automatic logic in_window(input logic [31:0] val, input logic [31:0] lo,
                                      input logic [31:0] len);
      return (val >= lo) && (val < (lo + len));
   endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-length delay line with asynchronous reset to a caller-supplied value; DEPTH 0 is a plain wire.
module sig_delay #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] rst_val,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_s;
         assign unused_s = ^{clk, rst, rst_val};
         assign dout     = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_r [DEPTH];

         // Shift register; every stage parks at the reset value while rst is high.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) stage_r[i] <= rst_val;
            end else begin
               stage_r[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
            end
         end

         assign dout = stage_r[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: pixel/line counters, sync/active/new-frame flags, frame count, delayed syncs.
// Defining VTG_LINE_IRQ_EN adds the line_sel_in / line_irq_out line-match interrupt.
module video_timing_gen
   import vtg_pkg::*;
#(
   parameter int H_ACTIVE   = int'(VTG_720P.h_active),
   parameter int H_FP       = int'(VTG_720P.h_fp),
   parameter int H_SYNC     = int'(VTG_720P.h_sync),
   parameter int H_BP       = int'(VTG_720P.h_bp),
   parameter int V_ACTIVE   = int'(VTG_720P.v_active),
   parameter int V_FP       = int'(VTG_720P.v_fp),
   parameter int V_SYNC     = int'(VTG_720P.v_sync),
   parameter int V_BP       = int'(VTG_720P.v_bp),
   parameter int SYNC_POS   = 1,
   parameter int PIPE_DEPTH = 4,
   parameter int FRAME_WRAP = 60,
   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW        = $clog2(H_TOTAL),
   localparam int VW        = $clog2(V_TOTAL),
   localparam int FW        = (FRAME_WRAP > 1) ? $clog2(FRAME_WRAP) : 1
) (
   input  logic          clk_pixel_in,
   input  logic          rst_in,
   output logic [HW-1:0] hcount_out,
   output logic [VW-1:0] vcount_out,
   output logic          hs_out,
   output logic          vs_out,
   output logic          ad_out,
   output logic          hs_d_out,
   output logic          vs_d_out,
   output logic          ad_d_out,
   output logic          nf_out,
`ifdef VTG_LINE_IRQ_EN
   output logic [FW-1:0] fc_out,
   input  logic [VW-1:0] line_sel_in,
   output logic          line_irq_out
`else
   output logic [FW-1:0] fc_out
`endif
);

   localparam logic          SYNC_ACT = (SYNC_POS != 0) ? 1'b1 : 1'b0;
   localparam logic [HW-1:0] H_MAX    = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_NF     = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_NF     = VW'(V_ACTIVE);
   localparam logic [FW-1:0] FC_MAX   = FW'(FRAME_WRAP - 1);

   logic [HW-1:0] h_r, h_nxt_s;
   logic [VW-1:0] v_r, v_nxt_s;
   logic [FW-1:0] fc_r;
   logic          hs_r, vs_r, ad_r, nf_r;
   logic          hs_nxt_s, vs_nxt_s, ad_nxt_s, nf_nxt_s;
   logic [2:0]    dly_in_s, dly_out_s;

   // Next position and the flags decoded from it, so each flag registers together with its counts.
   always_comb begin
      h_nxt_s = h_r + HW'(1);
      v_nxt_s = v_r;
      if (h_r == H_MAX) begin
         h_nxt_s = '0;
         if (v_r == V_MAX) begin
            v_nxt_s = '0;
         end else begin
            v_nxt_s = v_r + VW'(1);
         end
      end else begin
         h_nxt_s = h_r + HW'(1);
         v_nxt_s = v_r;
      end
      ad_nxt_s = (32'(h_nxt_s) < 32'(H_ACTIVE)) && (32'(v_nxt_s) < 32'(V_ACTIVE));
      hs_nxt_s = in_window(32'(h_nxt_s), 32'(H_ACTIVE + H_FP), 32'(H_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
      vs_nxt_s = in_window(32'(v_nxt_s), 32'(V_ACTIVE + V_FP), 32'(V_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
      nf_nxt_s = (h_nxt_s == H_NF) && (v_nxt_s == V_NF);
   end

   // Counters, flags and frame count; reset parks the counters on the last pixel of a frame.
   always_ff @(posedge clk_pixel_in or posedge rst_in) begin
      if (rst_in) begin
         h_r  <= H_MAX;
         v_r  <= V_MAX;
         hs_r <= ~SYNC_ACT;
         vs_r <= ~SYNC_ACT;
         ad_r <= 1'b0;
         nf_r <= 1'b0;
         fc_r <= '0;
      end else begin
         h_r  <= h_nxt_s;
         v_r  <= v_nxt_s;
         hs_r <= hs_nxt_s;
         vs_r <= vs_nxt_s;
         ad_r <= ad_nxt_s;
         nf_r <= nf_nxt_s;
         if (nf_nxt_s) begin
            fc_r <= (fc_r == FC_MAX) ? '0 : fc_r + FW'(1);
         end else begin
            fc_r <= fc_r;
         end
      end
   end

`ifdef VTG_LINE_IRQ_EN
   logic irq_r;

   // A selected line beyond the frame never matches because the line counter cannot reach it.
   always_ff @(posedge clk_pixel_in or posedge rst_in) begin
      if (rst_in) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= (h_nxt_s == H_NF) && (v_nxt_s == line_sel_in);
      end
   end

   assign line_irq_out = irq_r;
`endif

   assign dly_in_s = {hs_r, vs_r, ad_r};

   sig_delay #(
      .WIDTH (3),
      .DEPTH (PIPE_DEPTH)
   ) u_sync_dly (
      .clk     (clk_pixel_in),
      .rst     (rst_in),
      .rst_val ({~SYNC_ACT, ~SYNC_ACT, 1'b0}),
      .din     (dly_in_s),
      .dout    (dly_out_s)
   );

   assign hcount_out = h_r;
   assign vcount_out = v_r;
   assign hs_out     = hs_r;
   assign vs_out     = vs_r;
   assign ad_out     = ad_r;
   assign nf_out     = nf_r;
   assign fc_out     = fc_r;
   assign hs_d_out   = dly_out_s[2];
   assign vs_d_out   = dly_out_s[1];
   assign ad_d_out   = dly_out_s[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster (28x17), checked against a time-index reference model.
module tb_video_timing_gen;

   localparam int HA = 16, HFP = 4, HS = 3, HBP = 5;
   localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FT = HT * VT;
   localparam int PD = 4;
   localparam int WA = 60, WB = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] h_a, v_a, h_b, v_b;
   logic       hs_a, vs_a, ad_a, hsd_a, vsd_a, add_a, nf_a;
   logic       hs_b, vs_b, ad_b, hsd_b, vsd_b, add_b, nf_b;
   logic [5:0] fc_a;
   logic [1:0] fc_b;
   logic [4:0] sel = 5'd0;
   logic       irq_a, irq_b;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   video_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_POS(1), .PIPE_DEPTH(PD), .FRAME_WRAP(WA)) u_dut_a (
      .clk_pixel_in(clk), .rst_in(rst), .hcount_out(h_a), .vcount_out(v_a),
      .hs_out(hs_a), .vs_out(vs_a), .ad_out(ad_a), .hs_d_out(hsd_a), .vs_d_out(vsd_a),
      .ad_d_out(add_a), .nf_out(nf_a),
`ifdef VTG_LINE_IRQ_EN
      .line_sel_in(sel), .line_irq_out(irq_a),
`endif
      .fc_out(fc_a));

   video_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_POS(0), .PIPE_DEPTH(0), .FRAME_WRAP(WB)) u_dut_b (
      .clk_pixel_in(clk), .rst_in(rst), .hcount_out(h_b), .vcount_out(v_b),
      .hs_out(hs_b), .vs_out(vs_b), .ad_out(ad_b), .hs_d_out(hsd_b), .vs_d_out(vsd_b),
      .ad_d_out(add_b), .nf_out(nf_b),
`ifdef VTG_LINE_IRQ_EN
      .line_sel_in(sel), .line_irq_out(irq_b),
`endif
      .fc_out(fc_b));

`ifndef VTG_LINE_IRQ_EN
   assign irq_a = 1'b0;
   assign irq_b = 1'b0;
`endif

   // Reference model: t counts pixel clocks since the first edge after reset release.
   function automatic int m_h(int t); return t % HT; endfunction
   function automatic int m_v(int t); return (t / HT) % VT; endfunction
   function automatic logic m_ad(int t); return (m_h(t) < HA) && (m_v(t) < VA); endfunction
   function automatic logic m_hs(int t); return (m_h(t) >= HA + HFP) && (m_h(t) < HA + HFP + HS); endfunction
   function automatic logic m_vs(int t); return (m_v(t) >= VA + VFP) && (m_v(t) < VA + VFP + VS); endfunction
   function automatic logic m_nf(int t); return (m_h(t) == HA) && (m_v(t) == VA); endfunction
   function automatic int m_fc(int t, int wrap);
      int p;
      p = VA * HT + HA;
      if (t < p) return 0;
      return ((t - p) / FT + 1) % wrap;
   endfunction

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat ($urandom_range(2, 6)) @(posedge clk);
      #1;
      checks++; if (h_a !== 5'(HT - 1)) begin errors++; $display("FAIL rst_h got %0d exp %0d", h_a, HT - 1); end
      checks++; if (v_a !== 5'(VT - 1)) begin errors++; $display("FAIL rst_v got %0d exp %0d", v_a, VT - 1); end
      checks++; if ({hs_a, vs_a, ad_a, nf_a} !== 4'b0000) begin errors++; $display("FAIL rst_flags_a got %b exp 0000", {hs_a, vs_a, ad_a, nf_a}); end
      checks++; if ({hsd_a, vsd_a, add_a, irq_a} !== 4'b0000) begin errors++; $display("FAIL rst_dly_a got %b exp 0000", {hsd_a, vsd_a, add_a, irq_a}); end
      checks++; if (fc_a !== 6'd0) begin errors++; $display("FAIL rst_fc got %0d exp 0", fc_a); end
      checks++; if ({hs_b, vs_b, ad_b, nf_b, hsd_b, vsd_b, add_b} !== 7'b1100110) begin
         errors++; $display("FAIL rst_flags_b got %b exp 1100110", {hs_b, vs_b, ad_b, nf_b, hsd_b, vsd_b, add_b}); end
   endtask

   task automatic test_frames();
      int total, ad_cnt, nf_cnt, irq_cnt, hwraps, vwraps, prev_h, prev_v, prev_fc;
      bit fc_wrap;
      total = WA * FT + FT / 2;
      ad_cnt = 0; nf_cnt = 0; irq_cnt = 0; hwraps = 0; vwraps = 0; fc_wrap = 1'b0;
      prev_h = HT - 1; prev_v = VT - 1; prev_fc = 0;
      sel = 5'($urandom_range(0, VT - 1));
      release_reset();
      for (int t = 0; t < total; t++) begin
         @(posedge clk); #1;
         checks++; if (h_a !== 5'(m_h(t))) begin errors++; $display("FAIL h t=%0d got %0d exp %0d", t, h_a, m_h(t)); end
         checks++; if (v_a !== 5'(m_v(t))) begin errors++; $display("FAIL v t=%0d got %0d exp %0d", t, v_a, m_v(t)); end
         checks++; if ({hs_a, vs_a, ad_a, nf_a} !== {m_hs(t), m_vs(t), m_ad(t), m_nf(t)}) begin
            errors++; $display("FAIL flags t=%0d got %b exp %b", t, {hs_a, vs_a, ad_a, nf_a}, {m_hs(t), m_vs(t), m_ad(t), m_nf(t)}); end
         checks++; if (fc_a !== 6'(m_fc(t, WA))) begin errors++; $display("FAIL fc t=%0d got %0d exp %0d", t, fc_a, m_fc(t, WA)); end
         checks++;
         if (t >= PD) begin
            if ({hsd_a, vsd_a, add_a} !== {m_hs(t - PD), m_vs(t - PD), m_ad(t - PD)}) begin
               errors++; $display("FAIL dly4 t=%0d got %b exp %b", t, {hsd_a, vsd_a, add_a}, {m_hs(t - PD), m_vs(t - PD), m_ad(t - PD)}); end
         end else begin
            if ({hsd_a, vsd_a, add_a} !== 3'b000) begin errors++; $display("FAIL dly4_early t=%0d got %b exp 000", t, {hsd_a, vsd_a, add_a}); end
         end
         checks++; if ({h_b, v_b, hs_b, vs_b, ad_b, nf_b} !== {5'(m_h(t)), 5'(m_v(t)), ~m_hs(t), ~m_vs(t), m_ad(t), m_nf(t)}) begin
            errors++; $display("FAIL neg t=%0d got h%0d v%0d %b", t, h_b, v_b, {hs_b, vs_b, ad_b, nf_b}); end
         checks++; if ({hsd_b, vsd_b, add_b} !== {~m_hs(t), ~m_vs(t), m_ad(t)}) begin
            errors++; $display("FAIL dly0 t=%0d got %b exp %b", t, {hsd_b, vsd_b, add_b}, {~m_hs(t), ~m_vs(t), m_ad(t)}); end
         checks++; if (fc_b !== 2'(m_fc(t, WB))) begin errors++; $display("FAIL fc_b t=%0d got %0d exp %0d", t, fc_b, m_fc(t, WB)); end
`ifdef VTG_LINE_IRQ_EN
         checks++; if (irq_a !== ((m_h(t) == HA) && (m_v(t) == int'(sel)))) begin
            errors++; $display("FAIL irq t=%0d got %b sel %0d", t, irq_a, sel); end
         irq_cnt += int'(irq_a);
`endif
         ad_cnt += int'(ad_a);
         nf_cnt += int'(nf_a);
         if (prev_h == HT - 1 && h_a == 5'd0) hwraps++;
         if (prev_v == VT - 1 && v_a == 5'd0) vwraps++;
         if (prev_fc == WA - 1 && fc_a == 6'd0) fc_wrap = 1'b1;
         prev_h = int'(h_a); prev_v = int'(v_a); prev_fc = int'(fc_a);
         if (t % FT == FT - 1) begin
            checks++; if (ad_cnt != HA * VA) begin errors++; $display("FAIL ad_per_frame got %0d exp %0d", ad_cnt, HA * VA); end
            checks++; if (nf_cnt != 1) begin errors++; $display("FAIL nf_per_frame got %0d exp 1", nf_cnt); end
`ifdef VTG_LINE_IRQ_EN
            checks++; if (irq_cnt != 1) begin errors++; $display("FAIL irq_per_frame got %0d exp 1", irq_cnt); end
`endif
            ad_cnt = 0; nf_cnt = 0; irq_cnt = 0;
         end
      end
      checks++; if (hwraps != (total + HT - 1) / HT) begin errors++; $display("FAIL hwraps got %0d exp %0d", hwraps, (total + HT - 1) / HT); end
      checks++; if (vwraps != (total + FT - 1) / FT) begin errors++; $display("FAIL vwraps got %0d exp %0d", vwraps, (total + FT - 1) / FT); end
      checks++; if (!fc_wrap) begin errors++; $display("FAIL fc_wrap got no %0d->0 exp one", WA - 1); end
   endtask

   task automatic test_mid_reset();
      int th, tv;
      bit found;
      th = $urandom_range(1, HT - 2);
      tv = $urandom_range(1, VT - 2);
      found = 1'b0;
      for (int i = 0; i < FT + 2 && !found; i++) begin
         @(posedge clk); #1;
         if (h_a == 5'(th) && v_a == 5'(tv)) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL mid_wait got timeout exp (%0d,%0d)", th, tv); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({h_a, v_a} !== {5'(HT - 1), 5'(VT - 1)}) begin errors++; $display("FAIL mid_rst_cnt got (%0d,%0d) exp (%0d,%0d)", h_a, v_a, HT - 1, VT - 1); end
      checks++; if ({hs_a, vs_a, ad_a, nf_a, hsd_a, vsd_a, add_a} !== 7'd0) begin
         errors++; $display("FAIL mid_rst_flags got %b exp 0000000", {hs_a, vs_a, ad_a, nf_a, hsd_a, vsd_a, add_a}); end
      checks++; if (fc_a !== 6'd0) begin errors++; $display("FAIL mid_rst_fc got %0d exp 0", fc_a); end
      checks++; if ({hs_b, vs_b} !== 2'b11) begin errors++; $display("FAIL mid_rst_neg got %b exp 11", {hs_b, vs_b}); end
      release_reset();
      @(posedge clk); #1;
      checks++; if ({h_a, v_a, ad_a, nf_a} !== {5'd0, 5'd0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL post_rst got (%0d,%0d) ad%b nf%b exp (0,0) ad1 nf0", h_a, v_a, ad_a, nf_a); end
   endtask

`ifdef VTG_LINE_IRQ_EN
   task automatic test_line_irq_oob();
      int pulses;
      pulses = 0;
      rst = 1'b1;
      sel = 5'($urandom_range(VT, 31));
      repeat (2) @(posedge clk);
      release_reset();
      for (int t = 0; t < 2 * FT; t++) begin
         @(posedge clk); #1;
         pulses += int'(irq_a);
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL irq_oob sel=%0d got %0d pulses exp 0", sel, pulses); end
   endtask
`endif

   initial begin
      test_reset();
      test_frames();
      test_mid_reset();
`ifdef VTG_LINE_IRQ_EN
      test_line_irq_oob();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
